// File: rtl/alu_arbiter_if.sv
// ALU function encoding shared by the arbiter, the ALU and the requesters,
// plus the bundle of request, ALU-side and response signals around the arbiter.
package alu_arbiter_pkg;
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_func_e;

    localparam int FUNC_W = $bits(alu_func_e);
endpackage

// Handshake rules: a request transfers on an edge where req_valid[i] and
// req_ready[i] are both high, and a response transfers on an edge where
// rsp_valid and rsp_ready are both high. A valid source holds its payload
// stable until the transfer. req_ready is a function of req_valid, so a
// requester must never make req_valid depend on req_ready.
interface alu_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int N_REQ  = 2
);
    import alu_arbiter_pkg::*;
    localparam int ID_W = $clog2(N_REQ);

    // Requester side.
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_op_a;
    logic [N_REQ*DATA_W-1:0] req_op_b;
    logic [N_REQ*FUNC_W-1:0] req_func;

    // Shared combinational ALU side.
    logic [DATA_W-1:0]       alu_op_a;
    logic [DATA_W-1:0]       alu_op_b;
    alu_func_e               alu_func;
    logic [DATA_W-1:0]       alu_out;
    logic                    alu_signed_overflow;
    logic                    alu_carry_flag;

    // Response side.
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rsp_signed_overflow;
    logic                    rsp_carry_flag;

    // The arbiter itself.
    modport slave (
        input  req_valid, req_op_a, req_op_b, req_func,
        output req_ready,
        output alu_op_a, alu_op_b, alu_func,
        input  alu_out, alu_signed_overflow, alu_carry_flag,
        output rsp_valid, rsp_id, rsp_data, rsp_signed_overflow, rsp_carry_flag,
        input  rsp_ready
    );

    // Requesters, the ALU and the response consumer seen together.
    modport master (
        output req_valid, req_op_a, req_op_b, req_func,
        input  req_ready,
        input  alu_op_a, alu_op_b, alu_func,
        output alu_out, alu_signed_overflow, alu_carry_flag,
        input  rsp_valid, rsp_id, rsp_data, rsp_signed_overflow, rsp_carry_flag,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between N_REQ requesters.
// The granted request is routed to the ALU and its result is captured in a
// one-entry response register tagged with the requester index.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_REQ  = 2,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic        clk,
    input  logic        rst,
    alu_arbiter_if.slave bus
);

    // Rotating priority pointer: index searched first for the next grant.
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] grant_id;
    logic            grant_vld;
    logic            can_accept;
    logic            accept;

    // Requester index ptr+k, wrapped into 0..N_REQ-1.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % N_REQ;
        return s[ID_W-1:0];
    endfunction

    assign can_accept = !bus.rsp_valid || bus.rsp_ready;
    assign accept     = grant_vld && can_accept && !rst;

    // Round-robin search from ptr upwards; scanning downwards lets the
    // lowest offset with a valid request win the last assignment.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[wrap_idx(ptr, k)]) begin
                grant_vld = 1'b1;
                grant_id  = wrap_idx(ptr, k);
            end
        end
    end

    // One-hot ready to the grantee, only when the response slot can take it.
    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[grant_id] = 1'b1;
        end
    end

    // Route the grantee's operands to the ALU; idle cycles present zeros.
    always_comb begin
        bus.alu_op_a = '0;
        bus.alu_op_b = '0;
        bus.alu_func = alu_func_e'(0);
        if (grant_vld) begin
            bus.alu_op_a = bus.req_op_a[int'(grant_id)*DATA_W +: DATA_W];
            bus.alu_op_b = bus.req_op_b[int'(grant_id)*DATA_W +: DATA_W];
            bus.alu_func = alu_func_e'(bus.req_func[int'(grant_id)*FUNC_W +: FUNC_W]);
        end
    end

    // Response register and pointer: capture on accept, clear on drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_valid           <= 1'b0;
            bus.rsp_id              <= '0;
            bus.rsp_data            <= '0;
            bus.rsp_signed_overflow <= 1'b0;
            bus.rsp_carry_flag      <= 1'b0;
            ptr                     <= '0;
        end else if (accept) begin
            // A simultaneous drain is covered here: the new result overwrites.
            bus.rsp_valid           <= 1'b1;
            bus.rsp_id              <= grant_id;
            bus.rsp_data            <= bus.alu_out;
            bus.rsp_signed_overflow <= bus.alu_signed_overflow;
            bus.rsp_carry_flag      <= bus.alu_carry_flag;
            ptr                     <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        end else if (bus.rsp_valid && bus.rsp_ready) begin
            bus.rsp_valid           <= 1'b0;
        end
    end

endmodule
